dual_port_ram: RTL and testbench



---
 rtl/dual_port_ram_if.sv | 24 ++
 rtl/dual_port_ram.sv | 51 +++++
 tb/tb_dual_port_ram.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/dual_port_ram_if.sv
// Bus bundle for the compute RAM: port 1 (external/result traffic) and port 2 (operand stream).
interface dual_port_ram_if #(
   parameter int DATA_WIDTH = 40,
   parameter int ADDR_WIDTH = 9
);
   logic [ADDR_WIDTH-1:0] addr1;
   logic                  we1;
   logic [DATA_WIDTH-1:0] data1;
   logic [DATA_WIDTH-1:0] out1;
   logic [ADDR_WIDTH-1:0] addr2;
   logic                  we2;
   logic [DATA_WIDTH-1:0] data2;
   logic [DATA_WIDTH-1:0] out2;

   modport master (
      output addr1, we1, data1, addr2, we2, data2,
      input  out1, out2
   );

   modport slave (
      input  addr1, we1, data1, addr2, we2, data2,
      output out1, out2
   );
endinterface

// File: rtl/dual_port_ram.sv
// True dual-port synchronous RAM, one clock, registered read data with one-cycle latency.
// Reads return pre-write contents on a same-address collision; port 1 wins a write/write collision.
module dual_port_ram #(
   parameter int DATA_WIDTH = 40,
   parameter int ADDR_WIDTH = 9,
   parameter int DEPTH      = 512
) (
   input  logic              clk,
   input  logic              reset,
   dual_port_ram_if.slave    bus
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] out1_q, out1_d;
   logic [DATA_WIDTH-1:0] out2_q, out2_d;
   logic                  wr1_en;
   logic                  wr2_en;

   assign wr1_en = bus.we1;
   assign wr2_en = bus.we2 && !(bus.we1 && (bus.addr1 == bus.addr2));

   // Outputs only change on reads; a write cycle holds the last read value.
   always_comb begin
      out1_d = out1_q;
      out2_d = out2_q;
      if (!bus.we1) out1_d = mem_q[bus.addr1];
      if (!bus.we2) out2_d = mem_q[bus.addr2];
   end

   // Array is deliberately not reset; reset only blocks writes on the edges it covers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (wr1_en) mem_q[bus.addr1] <= bus.data1;
         if (wr2_en) mem_q[bus.addr2] <= bus.data2;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out1_q <= '0;
         out2_q <= '0;
      end else begin
         out1_q <= out1_d;
         out2_q <= out2_d;
      end
   end

   assign bus.out1 = out1_q;
   assign bus.out2 = out2_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// Self-checking bench for dual_port_ram: directed scenarios plus randomized traffic against an array model.
module tb_dual_port_ram;
   localparam int DW = 40;
   localparam int AW = 9;
   localparam int DP = 512;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   logic [DW-1:0] ref_mem [DP];
   logic [DW-1:0] m_out1;
   logic [DW-1:0] m_out2;

   dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rnd_word();
      return {8'($urandom), $urandom};
   endfunction

   // Drive one cycle of port activity from a falling edge, apply the memory rules to the
   // model at the rising edge, and return at the next falling edge for sampling.
   task automatic step(input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic w2, input logic [AW-1:0] a2, input logic [DW-1:0] d2);
      bus.we1 = w1; bus.addr1 = a1; bus.data1 = d1;
      bus.we2 = w2; bus.addr2 = a2; bus.data2 = d2;
      @(posedge clk);
      if (reset) begin
         m_out1 = '0;
         m_out2 = '0;
      end else begin
         if (!w1) m_out1 = ref_mem[a1];
         if (!w2) m_out2 = ref_mem[a2];
         if (w2) ref_mem[a2] = d2;
         if (w1) ref_mem[a1] = d1;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.we1 = 1'b0; bus.addr1 = '0; bus.data1 = '0;
      bus.we2 = 1'b0; bus.addr2 = '0; bus.data2 = '0;
      m_out1 = '0; m_out2 = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.out1 !== '0) begin n_fail++; $display("FAIL reset_out1 got %h want 0", bus.out1); end
      n_checks++;
      if (bus.out2 !== '0) begin n_fail++; $display("FAIL reset_out2 got %h want 0", bus.out2); end
      reset = 1'b0;
      step(1'b1, 9'd5, 40'hAB_CDEF_0123, 1'b0, 9'd5, '0);
      step(1'b0, 9'd5, '0, 1'b0, 9'd5, '0);
      n_checks++;
      if (bus.out2 !== 40'hAB_CDEF_0123) begin n_fail++; $display("FAIL reset_pre_out2 got %h want abcdef0123", bus.out2); end
      // Mid-cycle assertion: outputs must clear without waiting for an edge.
      #2 reset = 1'b1;
      m_out1 = '0; m_out2 = '0;
      #1;
      n_checks++;
      if (bus.out1 !== '0) begin n_fail++; $display("FAIL reset_async_out1 got %h want 0", bus.out1); end
      n_checks++;
      if (bus.out2 !== '0) begin n_fail++; $display("FAIL reset_async_out2 got %h want 0", bus.out2); end
      @(negedge clk);
      step(1'b1, 9'd5, 40'hDE_AD00_BEEF, 1'b1, 9'd6, 40'h12);
      n_checks++;
      if (bus.out1 !== '0 || bus.out2 !== '0) begin
         n_fail++; $display("FAIL reset_hold got %h/%h want 0/0", bus.out1, bus.out2);
      end
      reset = 1'b0;
      step(1'b0, 9'd5, '0, 1'b0, 9'd5, '0);
      n_checks++;
      if (bus.out1 !== 40'hAB_CDEF_0123) begin n_fail++; $display("FAIL reset_preserve got %h want abcdef0123", bus.out1); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DP / 2; i++)
         step(1'b1, AW'(2 * i), rnd_word(), 1'b1, AW'(2 * i + 1), rnd_word());
      for (int i = 0; i < 8; i++) begin
         step(1'b0, AW'($urandom_range(0, DP - 1)), '0, 1'b0, AW'($urandom_range(0, DP - 1)), '0);
         n_checks++;
         if (bus.out1 !== m_out1 || bus.out2 !== m_out2) begin
            n_fail++; $display("FAIL fill_readback got %h/%h want %h/%h", bus.out1, bus.out2, m_out1, m_out2);
         end
      end
   endtask

   task automatic test_latency();
      step(1'b0, 9'd50, '0, 1'b1, 9'd0, 40'h1);
      step(1'b0, 9'd50, '0, 1'b1, 9'd511, 40'h2);
      step(1'b0, 9'd0, '0, 1'b0, 9'd50, '0);
      n_checks++;
      if (bus.out1 !== 40'h1) begin n_fail++; $display("FAIL latency_addr0 got %h want 1", bus.out1); end
      step(1'b0, 9'd511, '0, 1'b0, 9'd50, '0);
      n_checks++;
      if (bus.out1 !== 40'h2) begin n_fail++; $display("FAIL latency_addr511 got %h want 2", bus.out1); end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 9'd3, rnd_word(), 1'b0, 9'd50, '0);
         n_checks++;
         if (bus.out1 !== 40'h2) begin n_fail++; $display("FAIL write_hold got %h want 2", bus.out1); end
      end
   endtask

   task automatic test_independent();
      step(1'b0, 9'd0, '0, 1'b1, 9'd20, 40'h77);
      step(1'b1, 9'd10, 40'h55, 1'b0, 9'd20, '0);
      n_checks++;
      if (bus.out2 !== 40'h77) begin n_fail++; $display("FAIL indep_read got %h want 77", bus.out2); end
      step(1'b0, 9'd10, '0, 1'b0, 9'd10, '0);
      n_checks++;
      if (bus.out2 !== 40'h55 || bus.out1 !== 40'h55) begin
         n_fail++; $display("FAIL indep_after got %h/%h want 55/55", bus.out1, bus.out2);
      end
   endtask

   task automatic test_ww_collision();
      step(1'b1, 9'd100, 40'hAAAA, 1'b1, 9'd100, 40'hBBBB);
      step(1'b0, 9'd100, '0, 1'b0, 9'd100, '0);
      n_checks++;
      if (bus.out1 !== 40'hAAAA || bus.out2 !== 40'hAAAA) begin
         n_fail++; $display("FAIL ww_collision got %h/%h want aaaa/aaaa", bus.out1, bus.out2);
      end
   endtask

   task automatic test_rw_collision();
      step(1'b1, 9'd7, 40'h11, 1'b0, 9'd8, '0);
      step(1'b1, 9'd7, 40'h22, 1'b0, 9'd7, '0);
      n_checks++;
      if (bus.out2 !== 40'h11) begin n_fail++; $display("FAIL rw_old_data got %h want 11", bus.out2); end
      step(1'b0, 9'd7, '0, 1'b0, 9'd7, '0);
      n_checks++;
      if (bus.out2 !== 40'h22 || bus.out1 !== 40'h22) begin
         n_fail++; $display("FAIL rw_new_data got %h/%h want 22/22", bus.out1, bus.out2);
      end
      // Mirror case: port 2 writes while port 1 reads the same word.
      step(1'b0, 9'd7, '0, 1'b1, 9'd7, 40'h33);
      n_checks++;
      if (bus.out1 !== 40'h22) begin n_fail++; $display("FAIL rw_mirror got %h want 22", bus.out1); end
   endtask

   task automatic test_streaming();
      for (int i = 0; i < 64; i++)
         step(1'b1, AW'(i), DW'(i), 1'b0, 9'd300, '0);
      for (int i = 0; i < 64; i++) begin
         step(1'b1, AW'(200 + i), rnd_word(), 1'b0, AW'(i), '0);
         n_checks++;
         if (bus.out2 !== DW'(i)) begin n_fail++; $display("FAIL stream_read[%0d] got %h want %h", i, bus.out2, DW'(i)); end
      end
      for (int i = 0; i < 64; i++) begin
         step(1'b0, AW'(i), '0, 1'b0, AW'(200 + i), '0);
         n_checks++;
         if (bus.out1 !== DW'(i) || bus.out2 !== m_out2) begin
            n_fail++; $display("FAIL stream_readback[%0d] got %h/%h want %h/%h", i, bus.out1, bus.out2, DW'(i), m_out2);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom), AW'($urandom_range(0, 15)), rnd_word(),
              1'($urandom), AW'($urandom_range(0, 15)), rnd_word());
         n_checks++;
         if (bus.out1 !== m_out1 || bus.out2 !== m_out2) begin
            n_fail++; $display("FAIL random[%0d] got %h/%h want %h/%h", i, bus.out1, bus.out2, m_out1, m_out2);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_fill();
      test_latency();
      test_independent();
      test_ww_collision();
      test_rw_collision();
      test_streaming();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
